key_debounce_bank: RTL and testbench



---
 rtl/key_debounce_bank.sv | 208 ++++++++++++++++++++
 tb/tb_key_debounce_bank.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_bank.sv
// key_debounce_bank: multi-channel key conditioner.
// Each raw key input is synchronised, polarity-normalised and debounced. Every
// channel then drives a clean level, press/release pulses, a long-press pulse and
// optional auto-repeat press pulses. A priority encoder reports the lowest-index
// press.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   key          raw asynchronous key inputs
//   key_level    debounced pressed state (1 = pressed)
//   key_press    1-cycle pulse on a debounced press and on each auto-repeat
//   key_release  1-cycle pulse on a debounced release
//   key_long     1-cycle pulse once a press has been held LONG_CYCLES
//   key_valid    1-cycle pulse when any key_press bit is set
//   key_code     index of the lowest set key_press bit, held otherwise
module key_debounce_bank #(
    parameter int unsigned N_KEYS        = 16,
    parameter int unsigned STABLE_CYCLES = 1500000,
    parameter int unsigned LONG_CYCLES   = 100000000,
    parameter int unsigned REPEAT_CYCLES = 20000000,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter bit          ACTIVE_HIGH   = 1'b1,
    parameter int unsigned CODE_W        = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code
);

    localparam int unsigned DB_W     = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    // Not-pressed raw value, loaded into the synchronisers on reset.
    localparam logic [N_KEYS-1:0] SYNC_IDLE = {N_KEYS{~ACTIVE_HIGH}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } hold_state_e;

    // Two-flop synchroniser per channel.
    logic [N_KEYS-1:0] sync1_q, sync1_d;
    logic [N_KEYS-1:0] sync2_q, sync2_d;
    logic [N_KEYS-1:0] samp;
    logic [N_KEYS-1:0] press_vec_d;

    always_comb begin
        sync1_d = key;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= SYNC_IDLE;
            sync2_q <= SYNC_IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Normalise so that samp = 1 means pressed.
    assign samp = ACTIVE_HIGH ? sync2_q : ~sync2_q;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
        logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              release_q, release_d;
        logic              long_q, long_d;
        hold_state_e       state_q, state_d;
        logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
        logic              rise, fall, rep;

        // Debounce: accept a change once STABLE_CYCLES consecutive samples differ.
        always_comb begin
            db_cnt_d = '0;
            level_d  = level_q;
            rise     = 1'b0;
            fall     = 1'b0;
            if (samp[gi] != level_q) begin
                if (db_cnt_q == DB_W'(STABLE_CYCLES - 1)) begin
                    level_d = ~level_q;
                    rise    = ~level_q;
                    fall    = level_q;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
        end

        // Hold FSM: long-press detection then periodic auto-repeat.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            long_d     = 1'b0;
            rep        = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_W'(LONG_CYCLES - 1)) begin
                        long_d     = 1'b1;
                        state_d    = ST_REPEAT;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (REPEAT_EN) begin
                        if (hold_cnt_q == HOLD_W'(REPEAT_CYCLES - 1)) begin
                            rep        = 1'b1;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end else begin
                        hold_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end
            endcase
            // Release overrides any long/repeat event on the same edge.
            if (fall) begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
                long_d     = 1'b0;
                rep        = 1'b0;
            end
        end

        always_comb begin
            press_d   = rise | rep;
            release_d = fall;
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                db_cnt_q   <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                long_q     <= 1'b0;
                state_q    <= ST_IDLE;
                hold_cnt_q <= '0;
            end else begin
                db_cnt_q   <= db_cnt_d;
                level_q    <= level_d;
                press_q    <= press_d;
                release_q  <= release_d;
                long_q     <= long_d;
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
            end
        end

        assign press_vec_d[gi] = press_d;
        assign key_level[gi]   = level_q;
        assign key_press[gi]   = press_q;
        assign key_release[gi] = release_q;
        assign key_long[gi]    = long_q;
    end

    // Priority encoder computed from next-cycle presses so valid/code align with key_press.
    logic              valid_q, valid_d;
    logic [CODE_W-1:0] code_q, code_d;

    always_comb begin
        valid_d = |press_vec_d;
        code_d  = code_q;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (press_vec_d[i]) begin
                code_d = CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

    assign key_valid = valid_q;
    assign key_code  = code_q;

endmodule

// File: tb/tb_key_debounce_bank.sv
// Bench for key_debounce_bank: three instances (repeat on, repeat off, active-low
// inputs driven with the inverted key vector) checked every cycle against an
// elapsed-time reference model, plus directed scenario checks.
module tb_key_debounce_bank;

    localparam int unsigned N = 4;
    localparam int unsigned S = 8;
    localparam int unsigned L = 20;
    localparam int unsigned R = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] key = '0;
    logic [N-1:0] key_n;

    assign key_n = ~key;

    logic [N-1:0] lvl_a, prs_a, rel_a, lng_a;
    logic [N-1:0] lvl_b, prs_b, rel_b, lng_b;
    logic [N-1:0] lvl_c, prs_c, rel_c, lng_c;
    logic         vld_a, vld_b, vld_c;
    logic [1:0]   code_a, code_b, code_c;

    key_debounce_bank #(.N_KEYS(N), .STABLE_CYCLES(S), .LONG_CYCLES(L), .REPEAT_CYCLES(R),
                        .REPEAT_EN(1'b1), .ACTIVE_HIGH(1'b1)) dut_a (
        .clk(clk), .rst(rst), .key(key), .key_level(lvl_a), .key_press(prs_a),
        .key_release(rel_a), .key_long(lng_a), .key_valid(vld_a), .key_code(code_a));

    key_debounce_bank #(.N_KEYS(N), .STABLE_CYCLES(S), .LONG_CYCLES(L), .REPEAT_CYCLES(R),
                        .REPEAT_EN(1'b0), .ACTIVE_HIGH(1'b1)) dut_b (
        .clk(clk), .rst(rst), .key(key), .key_level(lvl_b), .key_press(prs_b),
        .key_release(rel_b), .key_long(lng_b), .key_valid(vld_b), .key_code(code_b));

    key_debounce_bank #(.N_KEYS(N), .STABLE_CYCLES(S), .LONG_CYCLES(L), .REPEAT_CYCLES(R),
                        .REPEAT_EN(1'b1), .ACTIVE_HIGH(1'b0)) dut_c (
        .clk(clk), .rst(rst), .key(key_n), .key_level(lvl_c), .key_press(prs_c),
        .key_release(rel_c), .key_long(lng_c), .key_valid(vld_c), .key_code(code_c));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: sync delay line, accepted level, run of differing
    // samples, and edges elapsed since the accepted press (-1 when released).
    logic [N-1:0] m_p1, m_p2, m_level, m_press, m_rep, m_rel, m_long;
    int           m_run [N];
    int           m_held[N];
    logic         m_vld_a, m_vld_b;
    logic [1:0]   m_code_a, m_code_b;

    function automatic logic [1:0] lowest(input logic [N-1:0] v);
        logic [1:0] r = '0;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = 2'(i);
        return r;
    endfunction

    task automatic model_edge(input logic [N-1:0] k, input logic r);
        logic [N-1:0] samp;
        m_press = '0; m_rep = '0; m_rel = '0; m_long = '0;
        if (!r) begin
            m_p1 = '0; m_p2 = '0; m_level = '0;
            for (int i = 0; i < N; i++) begin m_run[i] = 0; m_held[i] = -1; end
            m_vld_a = 1'b0; m_vld_b = 1'b0; m_code_a = '0; m_code_b = '0;
        end else begin
            samp = m_p2; m_p2 = m_p1; m_p1 = k;
            for (int i = 0; i < N; i++) begin
                if (samp[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == int'(S)) begin
                        m_run[i] = 0;
                        m_level[i] = ~m_level[i];
                        if (m_level[i]) begin m_press[i] = 1'b1; m_held[i] = 0; end
                        else begin m_rel[i] = 1'b1; m_held[i] = -1; end
                    end
                end else begin
                    m_run[i] = 0;
                end
                if (m_level[i] && !m_press[i]) begin
                    m_held[i]++;
                    if (m_held[i] == int'(L)) m_long[i] = 1'b1;
                    else if (m_held[i] > int'(L) && ((m_held[i] - int'(L)) % int'(R)) == 0) m_rep[i] = 1'b1;
                end
            end
            m_vld_a = |(m_press | m_rep);
            if (m_vld_a) m_code_a = lowest(m_press | m_rep);
            m_vld_b = |m_press;
            if (m_vld_b) m_code_b = lowest(m_press);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        chk("a_level",   32'(lvl_a),  32'(m_level));
        chk("a_press",   32'(prs_a),  32'(m_press | m_rep));
        chk("a_release", 32'(rel_a),  32'(m_rel));
        chk("a_long",    32'(lng_a),  32'(m_long));
        chk("a_valid",   32'(vld_a),  32'(m_vld_a));
        chk("a_code",    32'(code_a), 32'(m_code_a));
        chk("b_level",   32'(lvl_b),  32'(m_level));
        chk("b_press",   32'(prs_b),  32'(m_press));
        chk("b_release", 32'(rel_b),  32'(m_rel));
        chk("b_long",    32'(lng_b),  32'(m_long));
        chk("b_valid",   32'(vld_b),  32'(m_vld_b));
        chk("b_code",    32'(code_b), 32'(m_code_b));
        chk("c_level",   32'(lvl_c),  32'(m_level));
        chk("c_press",   32'(prs_c),  32'(m_press | m_rep));
        chk("c_release", 32'(rel_c),  32'(m_rel));
        chk("c_long",    32'(lng_c),  32'(m_long));
        chk("c_valid",   32'(vld_c),  32'(m_vld_a));
        chk("c_code",    32'(code_c), 32'(m_code_a));
    endtask

    task automatic tick(input logic [N-1:0] k, input logic r);
        key = k;
        rst = r;
        @(posedge clk);
        model_edge(k, r);
        #1;
        cmp_all();
    endtask

    initial begin
        int idx;
        int cnt;
        int cnt2;
        logic [N-1:0] rk;

        m_p1 = '0; m_p2 = '0; m_level = '0; m_press = '0; m_rep = '0; m_rel = '0; m_long = '0;
        m_vld_a = 1'b0; m_vld_b = 1'b0; m_code_a = '0; m_code_b = '0;
        for (int i = 0; i < N; i++) begin m_run[i] = 0; m_held[i] = -1; end

        // Reset
        for (int t = 0; t < 3; t++) tick(4'b0000, 1'b0);
        chk("reset_level", 32'(lvl_a), 32'(0));
        chk("reset_code",  32'(code_a), 32'(0));
        for (int t = 0; t < 4; t++) tick(4'b0000, 1'b1);

        // 1: clean press of key[2], held 40, released
        idx = -1;
        for (int t = 0; t < 40; t++) begin
            tick(4'b0100, 1'b1);
            if (idx < 0 && lvl_a[2]) begin
                idx = t;
                chk("t1_press",  32'(prs_a), 32'(4'b0100));
                chk("t1_valid",  32'(vld_a), 32'(1));
                chk("t1_code",   32'(code_a), 32'(2));
            end
        end
        chk("t1_rise_edge", 32'(idx), 32'(9));
        idx = -1;
        for (int t = 0; t < 20; t++) begin
            tick(4'b0000, 1'b1);
            if (idx < 0 && rel_a[2]) idx = t;
        end
        chk("t1_release_edge", 32'(idx), 32'(9));

        // 2: bounce on key[0] every 3 cycles, then settle high
        cnt = 0; cnt2 = 0;
        for (int t = 0; t < 30; t++) begin
            tick(((t / 3) % 2 == 0) ? 4'b0001 : 4'b0000, 1'b1);
            if (lvl_b[0] || prs_b[0] || rel_b[0]) cnt++;
        end
        chk("t2_bounce_quiet", 32'(cnt), 32'(0));
        idx = -1;
        for (int t = 0; t < 25; t++) begin
            tick(4'b0001, 1'b1);
            if (prs_b[0]) begin cnt2++; if (idx < 0) idx = t; end
        end
        chk("t2_one_press", 32'(cnt2), 32'(1));
        chk("t2_press_edge", 32'(idx), 32'(9));
        for (int t = 0; t < 20; t++) tick(4'b0000, 1'b1);

        // 3: hold key[1]; repeats on dut_a, none on dut_b
        cnt = 0; cnt2 = 0; idx = 0;
        for (int t = 0; t < 60; t++) begin
            tick(4'b0010, 1'b1);
            if (prs_a[1]) cnt++;
            if (prs_b[1]) cnt2++;
            if (lng_a[1]) idx = t;
        end
        chk("t3_long_edge", 32'(idx), 32'(29));
        chk("t3_press_rep", 32'(cnt), 32'(7));
        chk("t3_press_norep", 32'(cnt2), 32'(1));
        for (int t = 0; t < 20; t++) tick(4'b0000, 1'b1);

        // 4: key[3] and key[1] together
        idx = -1;
        for (int t = 0; t < 15; t++) begin
            tick(4'b1010, 1'b1);
            if (idx < 0 && vld_a) begin
                idx = t;
                chk("t4_press", 32'(prs_a), 32'(4'b1010));
                chk("t4_code",  32'(code_a), 32'(1));
            end
        end
        chk("t4_edge", 32'(idx), 32'(9));
        for (int t = 0; t < 20; t++) tick(4'b0000, 1'b1);

        // 5: active-low instance sees key_n[0] low for 12 cycles, then a 5-cycle glitch
        idx = -1;
        for (int t = 0; t < 12; t++) begin
            tick(4'b0001, 1'b1);
            if (idx < 0 && prs_c[0]) idx = t;
        end
        chk("t5_press_edge", 32'(idx), 32'(9));
        for (int t = 0; t < 20; t++) tick(4'b0000, 1'b1);
        cnt = 0;
        for (int t = 0; t < 25; t++) begin
            tick((t < 5) ? 4'b0001 : 4'b0000, 1'b1);
            if (prs_c[0] || lvl_c[0] || rel_c[0]) cnt++;
        end
        chk("t5_glitch_quiet", 32'(cnt), 32'(0));

        // 6: reset while key[2] is in auto-repeat
        for (int t = 0; t < 40; t++) tick(4'b0100, 1'b1);
        tick(4'b0100, 1'b0);
        chk("t6_rst_level",   32'(lvl_a), 32'(0));
        chk("t6_rst_release", 32'(rel_a), 32'(0));
        chk("t6_rst_press",   32'(prs_a), 32'(0));
        idx = -1;
        for (int t = 0; t < 20; t++) begin
            tick(4'b0100, 1'b1);
            if (idx < 0 && prs_a[2]) idx = t;
        end
        chk("t6_repress_edge", 32'(idx), 32'(9));
        for (int t = 0; t < 20; t++) tick(4'b0000, 1'b1);

        // Random phase: sparse toggles give a mix of glitches, presses and long holds
        rk = '0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < 4) rk[i] = ~rk[i];
            end
            tick(rk, ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
